// File: rtl/bus_transaction_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// Packages shared by the bus transaction sequencer.
//   transactionGroup : controlBus transaction codes driven by the cpu32e2
//                      controller output register.
//   busSequencerPkg  : sequencer FSM states, lane count and the byte-enable
//                      mapping for each transaction code.
// No ports (package file).
// ---------------------------------------------------------------------------
package transactionGroup;

  typedef enum logic [3:0] {
    NO_OP       = 4'd0,
    READ        = 4'd1,
    WRITE_BYTE0 = 4'd2,
    WRITE_BYTE1 = 4'd3,
    WRITE_BYTE2 = 4'd4,
    WRITE_BYTE3 = 4'd5,
    WRITE_WORD0 = 4'd6,
    WRITE_WORD1 = 4'd7,
    WRITE_DWORD = 4'd8
  } controlBus;

endpackage

package busSequencerPkg;

  import transactionGroup::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } states;

  localparam int BYTE_LANES = 4;

  function automatic logic [BYTE_LANES-1:0] byteEnables(input controlBus t);
    logic [BYTE_LANES-1:0] be;
    case (t)
      READ, WRITE_DWORD: be = 4'b1111;
      WRITE_WORD0:       be = 4'b0011;
      WRITE_WORD1:       be = 4'b1100;
      WRITE_BYTE0:       be = 4'b0001;
      WRITE_BYTE1:       be = 4'b0010;
      WRITE_BYTE2:       be = 4'b0100;
      WRITE_BYTE3:       be = 4'b1000;
      default:           be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/bus_transaction_sequencer_lane_decoder.sv
// ---------------------------------------------------------------------------
// bus_lane_decoder
// Purely combinational mapping of a transaction code and right-justified
// store data onto the 4-lane bus: byte enables, lane-replicated write data
// and the write flag. The sequencer registers these into its bus outputs.
// Ports:
//   i_transaction  in   controlBus   transaction code
//   i_write_data   in   DATA_WIDTH   store data, right-justified
//   o_byte_enable  out  4            active byte lanes
//   o_write_data   out  DATA_WIDTH   replicated write data (0 for reads)
//   o_write        out  1            1 for any write code
// DATA_WIDTH is fixed at 32 (four byte lanes).
// ---------------------------------------------------------------------------
module bus_lane_decoder
  import transactionGroup::*;
  import busSequencerPkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  controlBus                 i_transaction,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  output logic [BYTE_LANES-1:0]     o_byte_enable,
  output logic [DATA_WIDTH-1:0]     o_write_data,
  output logic                      o_write
);

  always_comb begin
    o_byte_enable = byteEnables(i_transaction);
    o_write       = (i_transaction != READ) && (i_transaction != NO_OP);
    o_write_data  = '0;
    case (i_transaction)
      WRITE_BYTE0, WRITE_BYTE1, WRITE_BYTE2, WRITE_BYTE3:
        o_write_data = {BYTE_LANES{i_write_data[7:0]}};
      WRITE_WORD0, WRITE_WORD1:
        o_write_data = {(BYTE_LANES/2){i_write_data[15:0]}};
      WRITE_DWORD:
        o_write_data = i_write_data;
      default:
        o_write_data = '0;
    endcase
  end

endmodule

// File: rtl/bus_transaction_sequencer.sv
// ---------------------------------------------------------------------------
// bus_transaction_sequencer
// Runs one controller transaction code at a time on the req/ack memory bus.
// Bus fields are registered on accept and held until busAck; the controller
// is stalled from the accepting IDLE cycle through the final BUSY cycle.
// Optional feature macro: BUS_TIMEOUT_EN -- abort a BUSY phase that sees no
// ack for TIMEOUT_CYCLES cycles, returning readData=0 and a busError pulse.
//
// State table:
//   IDLE | waiting for a non-NO_OP code; accepting it raises stall
//   BUSY | request on the bus, fields frozen, waiting for busAck
//   DONE | single cycle, stall low so the controller advances
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   transaction         controlBus code from controller
//   address, writeData  byte address and right-justified store data
//   stall               hold controller (combinational)
//   readData            captured read data, valid in DONE
//   busError            timeout abort pulse (0 without BUS_TIMEOUT_EN)
//   busRequest/busWrite/busAddress/busByteEnable/busWriteData  bus request
//   busAck/busReadData  bus response
// ---------------------------------------------------------------------------
module bus_transaction_sequencer
  import transactionGroup::*;
  import busSequencerPkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  controlBus              transaction,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]  writeData,
  output logic                   stall,
  output logic [DATA_WIDTH-1:0]  readData,
  output logic                   busError,
  output logic                   busRequest,
  output logic                   busWrite,
  output logic [ADDR_WIDTH-1:0]  busAddress,
  output logic [BYTE_LANES-1:0]  busByteEnable,
  output logic [DATA_WIDTH-1:0]  busWriteData,
  input  logic                   busAck,
  input  logic [DATA_WIDTH-1:0]  busReadData
);

  states                  r_state;
  states                  w_state_next;
  logic                   r_bus_request, w_req_next;
  logic                   r_bus_write,   w_write_next;
  logic [ADDR_WIDTH-1:0]  r_bus_address, w_addr_next;
  logic [BYTE_LANES-1:0]  r_bus_be,      w_be_next;
  logic [DATA_WIDTH-1:0]  r_bus_wdata,   w_wdata_next;
  logic [DATA_WIDTH-1:0]  r_read_data,   w_rdata_next;
  logic                   r_bus_error,   w_err_next;

  logic [BYTE_LANES-1:0]  w_dec_be;
  logic [DATA_WIDTH-1:0]  w_dec_wdata;
  logic                   w_dec_write;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Count value seen during the last BUSY cycle allowed before abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_timeout_cnt, w_cnt_next;
  logic             w_unused;
  assign w_unused = ^address[1:0];
`else
  logic             w_unused;
  assign w_unused = ^{address[1:0], 32'(TIMEOUT_CYCLES)};
`endif

  bus_lane_decoder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_decoder (
    .i_transaction (transaction),
    .i_write_data  (writeData),
    .o_byte_enable (w_dec_be),
    .o_write_data  (w_dec_wdata),
    .o_write       (w_dec_write)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_bus_request <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_address <= '0;
      r_bus_be      <= '0;
      r_bus_wdata   <= '0;
      r_read_data   <= '0;
      r_bus_error   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_timeout_cnt <= '0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_bus_request <= w_req_next;
      r_bus_write   <= w_write_next;
      r_bus_address <= w_addr_next;
      r_bus_be      <= w_be_next;
      r_bus_wdata   <= w_wdata_next;
      r_read_data   <= w_rdata_next;
      r_bus_error   <= w_err_next;
`ifdef BUS_TIMEOUT_EN
      r_timeout_cnt <= w_cnt_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_bus_request;
    w_write_next = r_bus_write;
    w_addr_next  = r_bus_address;
    w_be_next    = r_bus_be;
    w_wdata_next = r_bus_wdata;
    w_rdata_next = r_read_data;
    w_err_next   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    w_cnt_next   = r_timeout_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (transaction != NO_OP) begin
          w_state_next = BUSY;
          w_req_next   = 1'b1;
          w_write_next = w_dec_write;
          w_addr_next  = {address[ADDR_WIDTH-1:2], 2'b00};
          w_be_next    = w_dec_be;
          w_wdata_next = w_dec_wdata;
`ifdef BUS_TIMEOUT_EN
          w_cnt_next   = '0;
`endif
        end
      end
      BUSY: begin
        if (busAck) begin
          // Ack in the terminal timeout cycle still completes normally.
          w_state_next = DONE;
          w_req_next   = 1'b0;
          if (!r_bus_write) w_rdata_next = busReadData;
        end
`ifdef BUS_TIMEOUT_EN
        else if (r_timeout_cnt == CNT_LAST) begin
          w_state_next = DONE;
          w_req_next   = 1'b0;
          w_rdata_next = '0;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next   = r_timeout_cnt + 1'b1;
        end
`endif
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Gated by reset_n so a held non-NO_OP code cannot stall during reset.
  assign stall = reset_n &&
                 (((r_state == IDLE) && (transaction != NO_OP)) || (r_state == BUSY));

  assign readData      = r_read_data;
  assign busError      = r_bus_error;
  assign busRequest    = r_bus_request;
  assign busWrite      = r_bus_write;
  assign busAddress    = r_bus_address;
  assign busByteEnable = r_bus_be;
  assign busWriteData  = r_bus_wdata;

endmodule

// File: tb/tb_bus_transaction_sequencer.sv
module tb_bus_transaction_sequencer;
  import transactionGroup::*;

  localparam int PERIOD = 10;
  localparam int TO     = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  controlBus   transaction;
  logic [31:0] address, writeData, readData, busAddress, busWriteData, busReadData;
  logic        stall, busError, busRequest, busWrite, busAck;
  logic [3:0]  busByteEnable;

  int checks   = 0;
  int failures = 0;

  // reference model state: last value readData should hold
  logic [31:0] m_read_data;

  // observations of one transaction
  int          ob_stall, ob_busy;
  logic        ob_req_idle, ob_stable, ob_err, ob_hang, ob_write;
  logic [31:0] ob_addr, ob_wdata, ob_rdata;
  logic [3:0]  ob_be;
  time         ob_t_ack, ob_t_req;

  always #(PERIOD/2) clk = ~clk;

  bus_transaction_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .transaction(transaction), .address(address),
    .writeData(writeData), .stall(stall), .readData(readData), .busError(busError),
    .busRequest(busRequest), .busWrite(busWrite), .busAddress(busAddress),
    .busByteEnable(busByteEnable), .busWriteData(busWriteData), .busAck(busAck),
    .busReadData(busReadData)
  );

  function automatic logic [3:0] exp_be(input controlBus t);
    if (t == READ || t == WRITE_DWORD) return 4'hF;
    if (t == WRITE_WORD0) return 4'h3;
    if (t == WRITE_WORD1) return 4'hC;
    if (t >= WRITE_BYTE0 && t <= WRITE_BYTE3) return 4'(1 << (int'(t) - int'(WRITE_BYTE0)));
    return 4'h0;
  endfunction

  function automatic logic [31:0] exp_wdata(input controlBus t, input logic [31:0] wd);
    if (t >= WRITE_BYTE0 && t <= WRITE_BYTE3) return {24'h0, wd[7:0]} * 32'h01010101;
    if (t == WRITE_WORD0 || t == WRITE_WORD1) return {16'h0, wd[15:0]} * 32'h00010001;
    if (t == WRITE_DWORD) return wd;
    return 32'h0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_read_data = 32'h0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      transaction = NO_OP;
      busAck = 1'b0;
    end
  endtask

  // Drives one transaction; ack is raised in BUSY cycle number ack_at.
  task automatic run_txn(input controlBus t, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_at, input int budget);
    @(negedge clk);
    transaction = t; address = a; writeData = wd; busAck = 1'b0;
    #1;
    ob_req_idle = busRequest;
    ob_stall = stall ? 1 : 0;
    ob_busy = 0; ob_stable = 1'b1; ob_t_ack = 0;
    @(negedge clk);
    ob_t_req = $time;
    ob_addr = busAddress; ob_be = busByteEnable; ob_wdata = busWriteData; ob_write = busWrite;
    for (int c = 0; c < budget && busRequest; c++) begin
      ob_busy++;
      if (stall) ob_stall++;
      if (busAddress !== ob_addr || busByteEnable !== ob_be || busWriteData !== ob_wdata ||
          busWrite !== ob_write || busError !== 1'b0) ob_stable = 1'b0;
      if (ob_busy == ack_at) begin
        busAck = 1'b1; busReadData = rd; ob_t_ack = $time;
      end
      @(negedge clk);
      busAck = 1'b0; busReadData = $urandom;
    end
    ob_hang = busRequest;
    if (stall) ob_stall++;
    ob_rdata = readData;
    ob_err   = busError;
    if (ob_hang) do_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; transaction = WRITE_DWORD; address = 32'h1234_5677;
    writeData = 32'hFFFF_FFFF; busAck = 1'b1; busReadData = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if ({busRequest, busWrite, busError} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got req/wr/err=%b exp=000", {busRequest, busWrite, busError});
    end
    checks++;
    if ({busAddress, busWriteData, readData, busByteEnable} !== 100'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wd=%h rd=%h be=%b exp all 0",
               busAddress, busWriteData, readData, busByteEnable);
    end
    @(negedge clk);
    transaction = NO_OP; busAck = 1'b0; reset_n = 1'b1;
    m_read_data = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (busRequest !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL noop_idle got req=%b stall=%b exp=0/0", busRequest, stall);
    end
  endtask

  task automatic test_read();
    run_txn(READ, 32'h0000_1004, $urandom, 32'hDEAD_BEEF, 2, 20);
    m_read_data = 32'hDEAD_BEEF;
    checks++;
    if (ob_addr !== 32'h1004 || ob_be !== 4'hF || ob_write !== 1'b0 || ob_wdata !== 32'h0) begin
      failures++;
      $display("FAIL read_fields got addr=%h be=%b wr=%b wd=%h exp 00001004/1111/0/0",
               ob_addr, ob_be, ob_write, ob_wdata);
    end
    checks++;
    if (ob_stall !== 3) begin failures++; $display("FAIL read_stall got=%0d exp=3", ob_stall); end
    checks++;
    if (ob_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL read_data got=%h exp=deadbeef", ob_rdata);
    end
    checks++;
    if (ob_busy !== 2 || ob_hang !== 1'b0 || ob_err !== 1'b0) begin
      failures++; $display("FAIL read_busy got busy=%0d hang=%b err=%b exp 2/0/0", ob_busy, ob_hang, ob_err);
    end
    idle_cycles(1);
  endtask

  task automatic test_write_byte();
    run_txn(WRITE_BYTE2, 32'h0000_2003, 32'h0000_00A5, $urandom, 1, 20);
    checks++;
    if (ob_be !== 4'b0100 || ob_wdata !== 32'hA5A5_A5A5 || ob_write !== 1'b1 || ob_addr !== 32'h2000) begin
      failures++;
      $display("FAIL wbyte_fields got be=%b wd=%h wr=%b addr=%h exp 0100/a5a5a5a5/1/00002000",
               ob_be, ob_wdata, ob_write, ob_addr);
    end
    checks++;
    if (ob_stable !== 1'b1 || ob_stall !== 2) begin
      failures++; $display("FAIL wbyte_timing got stable=%b stall=%0d exp 1/2", ob_stable, ob_stall);
    end
    checks++;
    if (ob_rdata !== m_read_data) begin
      failures++; $display("FAIL wbyte_rdata_kept got=%h exp=%h", ob_rdata, m_read_data);
    end
    idle_cycles(2);
  endtask

  task automatic test_write_word();
    int d;
    d = $urandom_range(1, 3);
    run_txn(WRITE_WORD1, 32'h0000_3002, 32'h0000_BEEF, $urandom, d, 20);
    checks++;
    if (ob_be !== 4'b1100 || ob_wdata !== 32'hBEEF_BEEF || ob_write !== 1'b1) begin
      failures++;
      $display("FAIL wword_fields got be=%b wd=%h wr=%b exp 1100/beefbeef/1", ob_be, ob_wdata, ob_write);
    end
    checks++;
    if (ob_stable !== 1'b1 || ob_stall !== d + 1) begin
      failures++; $display("FAIL wword_timing got stable=%b stall=%0d exp 1/%0d", ob_stable, ob_stall, d + 1);
    end
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    time  t_ack1;
    logic [31:0] rd, wd;
    rd = $urandom; wd = $urandom;
    run_txn(READ, 32'h0000_4000, 32'h0, rd, 1, 20);
    m_read_data = rd;
    t_ack1 = ob_t_ack;
    checks++;
    if (ob_rdata !== rd) begin failures++; $display("FAIL b2b_read got=%h exp=%h", ob_rdata, rd); end
    run_txn(WRITE_DWORD, 32'h0000_4008, wd, $urandom, 1, 20);
    checks++;
    if (ob_req_idle !== 1'b0) begin
      failures++; $display("FAIL b2b_stale_done got req_in_idle=%b exp=0", ob_req_idle);
    end
    checks++;
    if (ob_t_req - t_ack1 !== 3 * PERIOD) begin
      failures++; $display("FAIL b2b_gap got=%0t exp=%0d", ob_t_req - t_ack1, 3 * PERIOD);
    end
    checks++;
    if (ob_wdata !== wd || ob_be !== 4'hF || ob_write !== 1'b1 || ob_rdata !== m_read_data) begin
      failures++;
      $display("FAIL b2b_dword got wd=%h be=%b wr=%b rd=%h exp %h/1111/1/%h",
               ob_wdata, ob_be, ob_write, ob_rdata, wd, m_read_data);
    end
    idle_cycles(1);
    @(negedge clk);
    checks++;
    if (busRequest !== 1'b0) begin failures++; $display("FAIL b2b_duplicate got req=%b exp=0", busRequest); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    transaction = READ; address = 32'h0000_5000; busAck = 1'b0;
    @(negedge clk);
    checks++;
    if (busRequest !== 1'b1) begin failures++; $display("FAIL abort_pre got req=%b exp=1", busRequest); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busRequest !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL abort_async got req=%b stall=%b exp 0/0", busRequest, stall);
    end
    m_read_data = 32'h0;
    @(negedge clk);
    transaction = NO_OP; reset_n = 1'b1; busAck = 1'b1; busReadData = 32'h1357_9BDF;
    @(negedge clk);
    busAck = 1'b0;
    @(negedge clk);
    checks++;
    if ({busRequest, busWrite, busError, stall} !== 4'b0 || readData !== 32'h0 ||
        busAddress !== 32'h0 || busByteEnable !== 4'h0) begin
      failures++;
      $display("FAIL abort_spurious_ack got req=%b rd=%h addr=%h be=%b exp all 0",
               busRequest, readData, busAddress, busByteEnable);
    end
    run_txn(WRITE_BYTE0, 32'h0000_6001, 32'h0000_0077, $urandom, 1, 20);
    checks++;
    if (ob_be !== 4'b0001 || ob_wdata !== 32'h7777_7777 || ob_stall !== 2) begin
      failures++;
      $display("FAIL abort_restart got be=%b wd=%h stall=%0d exp 0001/77777777/2", ob_be, ob_wdata, ob_stall);
    end
    idle_cycles(1);
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd;
    run_txn(READ, 32'h0000_7000, 32'h0, $urandom, 1000, 20);
    m_read_data = 32'h0;
    checks++;
    if (ob_busy !== TO || ob_hang !== 1'b0 || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_abort got busy=%0d hang=%b err=%b rd=%h exp %0d/0/1/0",
               ob_busy, ob_hang, ob_err, ob_rdata, TO);
    end
    @(negedge clk);
    transaction = NO_OP;
    checks++;
    if (busError !== 1'b0) begin failures++; $display("FAIL timeout_pulse got err=%b exp=0", busError); end
    rd = $urandom;
    run_txn(READ, 32'h0000_7004, 32'h0, rd, TO, 20);
    m_read_data = rd;
    checks++;
    if (ob_busy !== TO || ob_err !== 1'b0 || ob_rdata !== rd) begin
      failures++;
      $display("FAIL timeout_ack_wins got busy=%0d err=%b rd=%h exp %0d/0/%h", ob_busy, ob_err, ob_rdata, TO, rd);
    end
    idle_cycles(1);
  endtask
`else
  task automatic test_timeout();
    logic [31:0] rd;
    rd = $urandom;
    run_txn(READ, 32'h0000_7000, 32'h0, rd, TO + 6, 30);
    m_read_data = rd;
    checks++;
    if (ob_busy !== TO + 6 || ob_err !== 1'b0 || ob_rdata !== rd || ob_stall !== TO + 7) begin
      failures++;
      $display("FAIL no_timeout got busy=%0d err=%b rd=%h stall=%0d exp %0d/0/%h/%0d",
               ob_busy, ob_err, ob_rdata, ob_stall, TO + 6, rd, TO + 7);
    end
    idle_cycles(1);
  endtask
`endif

  task automatic test_random();
    controlBus   t;
    logic [31:0] a, wd, rd;
    int          d;
    for (int i = 0; i < 40; i++) begin
      t  = controlBus'($urandom_range(1, 8));
      a  = $urandom; wd = $urandom; rd = $urandom;
      d  = $urandom_range(1, TO);
      run_txn(t, a, wd, rd, d, 20);
      if (t == READ) m_read_data = rd;
      checks++;
      if (ob_addr !== (a & 32'hFFFF_FFFC) || ob_be !== exp_be(t) ||
          ob_wdata !== exp_wdata(t, wd) || ob_write !== (t != READ)) begin
        failures++;
        $display("FAIL rand_fields[%0d] code=%0d got addr=%h be=%b wd=%h wr=%b exp %h/%b/%h/%b",
                 i, t, ob_addr, ob_be, ob_wdata, ob_write,
                 a & 32'hFFFF_FFFC, exp_be(t), exp_wdata(t, wd), (t != READ));
      end
      checks++;
      if (ob_stall !== d + 1 || ob_busy !== d || ob_stable !== 1'b1 || ob_req_idle !== 1'b0) begin
        failures++;
        $display("FAIL rand_timing[%0d] got stall=%0d busy=%0d stable=%b req_idle=%b exp %0d/%0d/1/0",
                 i, ob_stall, ob_busy, ob_stable, ob_req_idle, d + 1, d);
      end
      checks++;
      if (ob_rdata !== m_read_data || ob_err !== 1'b0) begin
        failures++;
        $display("FAIL rand_result[%0d] got rd=%h err=%b exp %h/0", i, ob_rdata, ob_err, m_read_data);
      end
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    busReadData = 32'h0;
    m_read_data = 32'h0;
    test_reset();
    test_read();
    test_write_byte();
    test_write_word();
    test_back_to_back();
    test_reset_abort();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
